// File: rtl/in_mem_pkg.sv
// Shared definitions for the SYS_ROW-banked input memory (read scheduler now,
// write controller later).
//   sched_state_e : read scheduler FSM states
//   beat_t        : one bank access {en, addr}
//   accum_row()   : accumulator rows per column group (ACCUM_SIZE / SYS_COL)
//   shamt()       : log2 of a power-of-two size, used as a shift amount
package in_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_FILL, ISSUE, DRAIN} sched_state_e;

  localparam int BEAT_ADDR_W = 16;

  typedef struct packed {
    logic                   en;
    logic [BEAT_ADDR_W-1:0] addr;
  } beat_t;

  function automatic int accum_row(input int accum_size, input int sys_col);
    return accum_size / sys_col;
  endfunction

  function automatic int shamt(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/in_mem_skew_pipe.sv
// Diagonal skew shift register for the input-bank reads.
//   in_en/in_addr : beat produced this cycle (stage 0, combinational pass-through)
//   hold          : freeze all stages (array back-pressure)
//   st_en/st_addr : stage i contents, destined for bank i
// Stage i holds a beat i advancing cycles after it entered, so bank i sees
// the same address exactly i cycles after bank 0.
module in_mem_skew_pipe #(
  parameter int STAGES = 16,
  parameter int AW     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic                         in_en,
  input  logic [AW-1:0]                in_addr,
  output logic [STAGES-1:0]            st_en,
  output logic [STAGES-1:0][AW-1:0]    st_addr
);

  logic [STAGES-1:1]         en_q;
  logic [STAGES-1:1][AW-1:0] addr_q;

  assign st_en   = {en_q, in_en};
  assign st_addr = {addr_q, in_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      addr_q <= '0;
    end else if (!hold) begin
      en_q   <= st_en[STAGES-2:0];
      addr_q <= st_addr[STAGES-2:0];
    end
  end

endmodule

// File: rtl/in_mem_rd_sched.sv
// Read-side scheduler for the banked input memory. Walks a written tile in
// K-chunk-major order (chunk c outer, row r inner) and issues skewed per-bank
// reads so data enters the systolic array diagonally.
//   clk, rst               : clock, async active-high reset
//   start                  : start pulse (IDLE only); num_rows/num_common latched
//   fill_ready             : tile present in banks (looked at in WAIT_FILL only)
//   stall                  : array back-pressure, freezes ISSUE/DRAIN
//   busy, done, cfg_err    : handshake / status to the layer controller
//   rd_en[i], rd_addr[i]   : registered read request for bank i
module in_mem_rd_sched
  import in_mem_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic [DATA_WIDTH-1:0] num_common,
  input  logic                  fill_ready,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [SYS_ROW-1:0]    rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr [SYS_ROW]
);

  localparam int ACCUM_ROW = accum_row(ACCUM_SIZE, SYS_COL);
  localparam int LOG_ROW   = shamt(SYS_ROW);
  localparam int LOG_AR    = shamt(ACCUM_ROW);
  localparam int CW        = DATA_WIDTH - LOG_ROW;    // K-chunk counter width
  localparam int DW        = shamt(SYS_ROW + RD_LAT) + 1;
  // Drain ends once bank SYS_ROW-1 has issued the last beat and RD_LAT more
  // advancing cycles have passed.
  localparam logic [DW-1:0] DRN_LAST = DW'(SYS_ROW + RD_LAT - 1);

  sched_state_e                     state, state_d;
  logic [CW-1:0]                    nc_in, nc_m1, c_cnt;
  logic [LOG_AR-1:0]                rows_m1, r_cnt;
  logic [DW-1:0]                    drn_cnt;
  logic                             cfg_bad, last_beat, beat_en;
  logic [ADDR_WIDTH-1:0]            beat_addr;
  logic [SYS_ROW-1:0]               st_en;
  logic [SYS_ROW-1:0][ADDR_WIDTH-1:0] st_addr;

  assign nc_in   = num_common[DATA_WIDTH-1:LOG_ROW];
  assign cfg_bad = (nc_in == '0) || (num_rows == '0) ||
                   (32'(num_rows) > 32'(ACCUM_ROW)) ||
                   (num_common[LOG_ROW-1:0] != '0);

  assign last_beat = (c_cnt == nc_m1) && (r_cnt == rows_m1);
  // r < ACCUM_ROW, so concatenation equals (c << log2(ACCUM_ROW)) + r.
  assign beat_addr = ADDR_WIDTH'({c_cnt, r_cnt});

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    beat_en = 1'b0;
    case (state)
      IDLE: if (start) begin
        busy = 1'b1;
        if (cfg_bad) done = 1'b1;     // reject: one-cycle busy/done, no reads
        else         state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        busy = 1'b1;
        if (fill_ready) state_d = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (!stall) begin
          beat_en = 1'b1;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!stall && drn_cnt == DRN_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cfg_err <= 1'b0;
      nc_m1   <= '0;
      rows_m1 <= '0;
      c_cnt   <= '0;
      r_cnt   <= '0;
      drn_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        cfg_err <= cfg_bad;
        nc_m1   <= nc_in - 1'b1;
        rows_m1 <= num_rows[LOG_AR-1:0] - 1'b1;  // num_rows==ACCUM_ROW wraps to all-ones
        c_cnt   <= '0;
        r_cnt   <= '0;
        drn_cnt <= '0;
      end
      if (beat_en) begin
        if (r_cnt == rows_m1) begin
          r_cnt <= '0;
          c_cnt <= c_cnt + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (state == DRAIN && !stall) drn_cnt <= drn_cnt + 1'b1;
    end
  end

  in_mem_skew_pipe #(.STAGES(SYS_ROW), .AW(ADDR_WIDTH)) u_skew (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .in_en   (beat_en),
    .in_addr (beat_addr),
    .st_en   (st_en),
    .st_addr (st_addr)
  );

  // A stalled cycle yields no read next cycle; the address is left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en <= '0;
      for (int i = 0; i < SYS_ROW; i++) rd_addr[i] <= '0;
    end else begin
      for (int i = 0; i < SYS_ROW; i++) begin
        rd_en[i] <= st_en[i] & ~stall;
        if (st_en[i] && !stall) rd_addr[i] <= st_addr[i];
      end
    end
  end

endmodule

// File: doc/in_mem_rd_sched.md
Name: in_mem_rd_sched

Overview:
Read-side scheduler for the SYS_ROW-banked input memory. After a tile has been written into the banks, it walks the tile in K-chunk-major order and issues per-bank reads. The address for bank i is skewed by i cycles, so data enters the systolic array diagonally. Start/done handshake to the layer controller, fill gating from the write side, and a stall input from the array.

Parameters:
SYS_ROW, 16, number of input banks / array rows (power of two)
SYS_COL, 16, array columns (sets ACCUM_ROW)
DATA_WIDTH, 16, width of num_common
ADDR_WIDTH, 16, bank address width
ACCUM_SIZE, 1024, accumulator entries; ACCUM_ROW = ACCUM_SIZE/SYS_COL (localparam, power of two)
RD_LAT, 1, bank read latency in cycles (1..2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  start pulse; sampled only in IDLE
num_rows  in  ADDR_WIDTH  input rows in tile (M), latched at start
num_common  in  DATA_WIDTH  reduction length (K), latched at start
fill_ready  in  1  write side has completed the tile in the banks
stall  in  1  array back-pressure; freezes the schedule
busy  out  1  high from accepted start until the cycle done is high, inclusive
done  out  1  one-cycle completion pulse
cfg_err  out  1  config error flag; sticky until next accepted start
rd_en  out  SYS_ROW  per-bank read enable
rd_addr  out  ADDR_WIDTH x SYS_ROW  per-bank read address (unpacked array)

Behaviour:
- Reset (async, rst=1): state IDLE. busy=0, done=0, cfg_err=0, rd_en=0, all rd_addr=0, all counters/pipe stages 0.
- Derived values: NC = num_common >> log2(SYS_ROW). Beat address = (c << log2(ACCUM_ROW)) + r. Width-truncate to ADDR_WIDTH.
- Config check at start: error if NC==0, num_rows==0, num_rows>ACCUM_ROW, or num_common[log2(SYS_ROW)-1:0]!=0.
- On error: cfg_err=1 next cycle, done pulses the same cycle, busy=1 only in that cycle, no reads issued, return to IDLE.
- FSM:
  - IDLE: start=1 with valid config -> WAIT_FILL. Latch config, busy=1.
  - WAIT_FILL: fill_ready=1 -> ISSUE.
  - ISSUE: one beat per non-stalled cycle, order c=0..NC-1 outer, r=0..num_rows-1 inner. After beat (NC-1, num_rows-1) -> DRAIN.
  - DRAIN: wait until the skew pipe is empty and RD_LAT cycles have elapsed after the last rd_en of bank SYS_ROW-1 -> IDLE. done=1 and busy=1 in that final cycle.
- Skew pipe:
  - Beat enters stage 0; stage i feeds bank i.
  - Registered outputs: rd_en[i]/rd_addr[i] <= stage[i].
  - Bank 0 rd_en asserts 1 cycle after the beat is generated in ISSUE.
  - Bank i asserts exactly i cycles after bank 0 for the same beat, with the same address.
- Stall:
  - In a cycle with stall=1, counters and pipe stages hold, and next-cycle rd_en=0 on all banks; rd_addr holds.
  - Resume on the cycle after stall=0 with no beat lost or duplicated.
  - stall is ignored in IDLE and WAIT_FILL.
- start while busy: ignored, not queued.
- fill_ready is sampled only in WAIT_FILL; dropping it during ISSUE has no effect.
- Reset mid-operation: immediate abort to reset values; no done pulse.
- Beat count = NC*num_rows; max ACCUM_ROW*(2^DATA_WIDTH/SYS_ROW). Counters are sized accordingly and never wrap within a tile.

Decomposition:
- Package in_mem_pkg: sched_state_e enum (IDLE, WAIT_FILL, ISSUE, DRAIN), ACCUM_ROW/shift-amount helper functions, beat struct {en, addr}. Shared later with the write controller.
- One sub-module, in_mem_skew_pipe: SYS_ROW-stage beat shift register with hold enable.

Test Plan:
Test configuration: SYS_ROW=4, SYS_COL=4, ACCUM_SIZE=64 (ACCUM_ROW=16), RD_LAT=1.
- Basic: num_rows=3, num_common=8, fill_ready high -> bank0 addresses 0,1,2,16,17,18 on 6 consecutive cycles; bank3 gives the same sequence delayed 3 cycles; done 1 cycle after bank3's last rd_en; exactly 24 total rd_en assertions.
- Fill gating: fill_ready held low 10 cycles after start -> busy=1, no rd_en; first bank0 rd_en 2 cycles after fill_ready rises.
- Stall: stall=1 for 3 cycles mid-tile -> no rd_en during freeze; address sequence per bank unchanged, none skipped or duplicated; done delayed by exactly 3 cycles.
- Config error: num_common=6 (and separately num_rows=17) -> cfg_err=1, done pulse, zero rd_en; next valid start clears cfg_err.
- Boundary: num_rows=16, num_common=4 -> bank0 addresses 0..15; second start during busy ignored; next start after done runs normally.
- Reset mid-ISSUE: assert rst -> all outputs 0 immediately, no done pulse, state IDLE; new start runs full sequence from address 0.
